// File: rtl/multi_cycle_processor_if.sv
// Instruction/result channel of the multi-cycle core.
interface multi_cycle_processor_if #(
    parameter int unsigned DATA_W = 32
);
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic              err;

    modport master (
        output inst_valid, inst,
        input  inst_ready, result_valid, result, err
    );

    modport slave (
        input  inst_valid, inst,
        output inst_ready, result_valid, result, err
    );
endinterface

// File: rtl/multi_cycle_processor.sv
// Multi-cycle load/store core: one instruction at a time, register file plus
// single-port synchronous data RAM, result returned as a one-cycle pulse.
module multi_cycle_processor #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input logic                    clk,
    input logic                    rst,
    multi_cycle_processor_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StMem, StDone} state_e;
    typedef enum logic [2:0] {OpNop, OpLw, OpSw, OpAdd, OpSub, OpAnd, OpOr, OpLi} op_e;

    state_e            state_q, state_d;
    logic [31:0]       inst_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic              lw_err_q;
    logic [DATA_W-1:0] result_q;
    logic              err_q;

    op_e               op;
    logic [4:0]        rd, rs1, rs2;
    logic [15:0]       imm;
    logic              rd_bad, rs1_bad, rs2_bad, addr_bad, exec_err;
    logic [DATA_W-1:0] rs1_val, rs2_val, alu_val;
    logic [AW-1:0]     addr;
    logic              rf_we, ram_we, ram_re;
    logic [DATA_W-1:0] rf_wdata;

    assign op       = op_e'(inst_q[31:29]);
    assign rd       = inst_q[28:24];
    assign rs1      = inst_q[23:19];
    assign rs2      = inst_q[18:14];
    assign imm      = inst_q[15:0];
    assign rd_bad   = 32'(rd) >= NUM_REGS;
    assign rs1_bad  = 32'(rs1) >= NUM_REGS;
    assign rs2_bad  = 32'(rs2) >= NUM_REGS;
    assign addr_bad = 32'(imm) >= MEM_DEPTH;
    assign addr     = imm[AW-1:0];

    // Operand read, range checks and ALU; only indices the opcode uses can fault.
    always_comb begin
        rs1_val  = '0;
        rs2_val  = '0;
        alu_val  = '0;
        exec_err = 1'b0;
        if (rs1 != 5'd0 && !rs1_bad) rs1_val = regs_q[rs1[IDX_W-1:0]];
        if (rs2 != 5'd0 && !rs2_bad) rs2_val = regs_q[rs2[IDX_W-1:0]];
        case (op)
            OpNop:   exec_err = 1'b0;
            OpLw:    exec_err = rd_bad | addr_bad;
            OpSw:    exec_err = rs1_bad | addr_bad;
            OpLi:    exec_err = rd_bad;
            default: exec_err = rd_bad | rs1_bad | rs2_bad;
        endcase
        case (op)
            OpSw:    alu_val = rs1_val;
            OpAdd:   alu_val = rs1_val + rs2_val;
            OpSub:   alu_val = rs1_val - rs2_val;
            OpAnd:   alu_val = rs1_val & rs2_val;
            OpOr:    alu_val = rs1_val | rs2_val;
            OpLi:    alu_val = DATA_W'(imm);
            default: alu_val = '0;
        endcase
    end

    // Write-back and RAM strobes; nothing is written for a faulting instruction.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_val;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        if (state_q == StExec && !exec_err) begin
            rf_we  = (rd != 5'd0) && (op inside {OpAdd, OpSub, OpAnd, OpOr, OpLi});
            ram_we = (op == OpSw);
            ram_re = (op == OpLw);
        end
        if (state_q == StMem && !lw_err_q && rd != 5'd0) begin
            rf_we    = 1'b1;
            rf_wdata = ram_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.inst_valid) state_d = StExec;
            StExec: state_d = (op == OpLw) ? StMem : StDone;
            StMem:  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control state, latched instruction and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            inst_q   <= '0;
            lw_err_q <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.inst_valid) inst_q <= bus.inst;
            if (state_q == StExec) begin
                lw_err_q <= exec_err;
                if (op != OpLw) begin
                    result_q <= exec_err ? '0 : alu_val;
                    err_q    <= exec_err;
                end
            end
            if (state_q == StMem) begin
                result_q <= lw_err_q ? '0 : ram_q;
                err_q    <= lw_err_q;
            end
        end
    end

    // Register file; cleared by reset, r0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rd[IDX_W-1:0]] <= rf_wdata;
        end
    end

    // Single-port data RAM with registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr] <= rs1_val;
        end else if (ram_re) begin
            ram_q <= mem[addr];
        end
    end

    assign bus.inst_ready   = (state_q == StIdle);
    assign bus.result_valid = (state_q == StDone);
    assign bus.result       = result_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_multi_cycle_processor.sv
// Directed bench for multi_cycle_processor (NUM_REGS = 8, MEM_DEPTH = 256).
module tb_multi_cycle_processor;
    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    localparam logic [2:0] NOP = 3'd0, LW = 3'd1, SW = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, AND = 3'd5, OR = 3'd6, LI = 3'd7;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multi_cycle_processor_if #(.DATA_W(32)) bus ();

    multi_cycle_processor #(
        .DATA_W   (32),
        .NUM_REGS (8),
        .MEM_DEPTH(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] enc_r(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1,
                                          logic [4:0] rs2);
        return {op, rd, rs1, rs2, 14'b0};
    endfunction

    function automatic logic [31:0] enc_i(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1,
                                          logic [15:0] imm);
        return {op, rd, rs1, 3'b000, imm};
    endfunction

    function automatic void add_vec(string name, logic [31:0] ins, logic [31:0] res,
                                    logic err, int lat);
        vec_t v;
        v.name = name; v.ins = ins; v.res = res; v.err = err; v.lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction and check result, err, latency, pulse width and hold.
    task automatic run_vec(string name, logic [31:0] ins, logic [31:0] exp_res, logic exp_err,
                           int exp_lat);
        int lat = 0;
        @(negedge clk);
        for (int i = 0; i < 10 && !bus.inst_ready; i++) @(negedge clk);
        check({name, " ready"}, 32'(bus.inst_ready), 32'd1);
        bus.inst_valid = 1'b1;
        bus.inst       = ins;
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.result_valid) lat = i;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, bus.result, exp_res);
        check({name, " err"}, 32'(bus.err), 32'(exp_err));
        @(negedge clk);
        check({name, " pulse"}, 32'(bus.result_valid), 32'd0);
        check({name, " hold"}, bus.result, exp_res);
    endtask

    initial begin
        logic [31:0] dbl;

        // Stimulus table
        add_vec("li_r1",   enc_i(LI, 5'd1, 5'd0, 16'h1234), 32'h1234, 1'b0, 2);
        add_vec("li_r2",   enc_i(LI, 5'd2, 5'd0, 16'h0010), 32'h0010, 1'b0, 2);
        add_vec("add_r3",  enc_r(ADD, 5'd3, 5'd1, 5'd2),    32'h1244, 1'b0, 2);
        add_vec("li_r4",   enc_i(LI, 5'd4, 5'd0, 16'hBEEF), 32'hBEEF, 1'b0, 2);
        add_vec("sw_5",    enc_i(SW, 5'd0, 5'd4, 16'h0005), 32'hBEEF, 1'b0, 2);
        add_vec("li_r4_0", enc_i(LI, 5'd4, 5'd0, 16'h0000), 32'h0,    1'b0, 2);
        add_vec("lw_5",    enc_i(LW, 5'd5, 5'd0, 16'h0005), 32'hBEEF, 1'b0, 3);
        add_vec("li_r6",   enc_i(LI, 5'd6, 5'd0, 16'h0077), 32'h0077, 1'b0, 2);
        add_vec("lw_oob",  enc_i(LW, 5'd6, 5'd0, 16'h0100), 32'h0,    1'b1, 3);
        add_vec("r6_keep", enc_r(ADD, 5'd7, 5'd6, 5'd0),    32'h0077, 1'b0, 2);
        add_vec("sw_ff",   enc_i(SW, 5'd0, 5'd5, 16'h00FF), 32'hBEEF, 1'b0, 2);
        add_vec("lw_ff",   enc_i(LW, 5'd1, 5'd0, 16'h00FF), 32'hBEEF, 1'b0, 3);
        add_vec("sw_oob",  enc_i(SW, 5'd0, 5'd5, 16'h0100), 32'h0,    1'b1, 2);
        add_vec("li_ffff", enc_i(LI, 5'd1, 5'd0, 16'hFFFF), 32'h0000FFFF, 1'b0, 2);
        add_vec("li2ffff", enc_i(LI, 5'd2, 5'd0, 16'hFFFF), 32'h0000FFFF, 1'b0, 2);
        dbl = 32'h0000FFFF;
        for (int k = 1; k <= 16; k++) begin
            dbl = dbl + dbl;
            add_vec($sformatf("dbl%0d", k), enc_r(ADD, 5'd2, 5'd2, 5'd2), dbl, 1'b0, 2);
        end
        add_vec("or_all",  enc_r(OR, 5'd3, 5'd1, 5'd2),    32'hFFFFFFFF, 1'b0, 2);
        add_vec("li_one",  enc_i(LI, 5'd4, 5'd0, 16'h0001), 32'h1,        1'b0, 2);
        add_vec("add_wrap", enc_r(ADD, 5'd5, 5'd3, 5'd4),   32'h0,        1'b0, 2);
        add_vec("sub_wrap", enc_r(SUB, 5'd6, 5'd0, 5'd4),   32'hFFFFFFFF, 1'b0, 2);
        add_vec("and_lo",  enc_r(AND, 5'd7, 5'd3, 5'd1),    32'h0000FFFF, 1'b0, 2);
        add_vec("li_r0",   enc_i(LI, 5'd0, 5'd0, 16'h0055), 32'h0055,     1'b0, 2);
        add_vec("r0_zero", enc_r(ADD, 5'd7, 5'd0, 5'd0),    32'h0,        1'b0, 2);
        add_vec("rd_oob",  enc_r(ADD, 5'd9, 5'd1, 5'd1),    32'h0,        1'b1, 2);
        add_vec("rs2_oob", enc_r(SUB, 5'd3, 5'd1, 5'd31),   32'h0,        1'b1, 2);
        add_vec("li_rs1x", enc_i(LI, 5'd3, 5'd31, 16'h00AB), 32'h00AB,    1'b0, 2);
        add_vec("nop",     enc_r(NOP, 5'd31, 5'd31, 5'd31), 32'h0,        1'b0, 2);

        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        check("rst ready", 32'(bus.inst_ready), 32'd1);
        check("rst valid", 32'(bus.result_valid), 32'd0);
        check("rst result", bus.result, 32'h0);
        check("rst err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].ins, vecs[i].res, vecs[i].err, vecs[i].lat);

        // A held inst_valid during EXEC/MEM/DONE must not be accepted.
        @(negedge clk);
        bus.inst_valid = 1'b1;
        bus.inst       = enc_i(LW, 5'd2, 5'd0, 16'h0005);
        @(posedge clk);
        #1;
        bus.inst = enc_i(LI, 5'd2, 5'd0, 16'h0099);
        @(negedge clk);
        check("busy exec ready", 32'(bus.inst_ready), 32'd0);
        @(negedge clk);
        check("busy mem ready", 32'(bus.inst_ready), 32'd0);
        check("busy mem valid", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        check("busy done ready", 32'(bus.inst_ready), 32'd0);
        check("busy done valid", 32'(bus.result_valid), 32'd1);
        check("busy done result", bus.result, 32'hBEEF);
        bus.inst_valid = 1'b0;
        run_vec("busy r2", enc_r(ADD, 5'd7, 5'd2, 5'd0), 32'hBEEF, 1'b0, 2);

        // Reset during the MEM cycle of a load.
        run_vec("li_r5", enc_i(LI, 5'd5, 5'd0, 16'h4321), 32'h4321, 1'b0, 2);
        @(negedge clk);
        bus.inst_valid = 1'b1;
        bus.inst       = enc_i(LW, 5'd5, 5'd0, 16'h0005);
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mem ready", 32'(bus.inst_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("arst ready", 32'(bus.inst_ready), 32'd1);
        check("arst valid", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        check("arst result", bus.result, 32'h0);
        check("arst valid2", 32'(bus.result_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post rst valid", 32'(bus.result_valid), 32'd0);
        check("post rst ready", 32'(bus.inst_ready), 32'd1);
        run_vec("r5 cleared", enc_r(ADD, 5'd7, 5'd5, 5'd0), 32'h0, 1'b0, 2);
        run_vec("r2 cleared", enc_r(OR, 5'd7, 5'd2, 5'd0), 32'h0, 1'b0, 2);
        run_vec("ram kept", enc_i(LW, 5'd1, 5'd0, 16'h0005), 32'hBEEF, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_cycle_processor.md
Name: multi_cycle_processor

Overview:
- Parametrised multi-cycle successor to the single-cycle load/store core.
- Accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it and executes it against an internal register file and a single-port data RAM.
- Returns a result on a one-cycle-pulsed result channel.
- Adds ALU ops, load-immediate, address range checking and reset.

Parameters:
- DATA_W, 32, width of registers, RAM words and result.
- NUM_REGS, 32, register file entries, 2..32; index field is always 5 bits.
- MEM_DEPTH, 256, data RAM words, 2..65536.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst_valid  input  1  inst holds a valid instruction.
- inst_ready  output  1  core can accept an instruction.
- inst  input  32  instruction word.
- result_valid  output  1  one-cycle pulse: result/err valid.
- result  output  DATA_W  value produced by the completed instruction.
- err  output  1  completed instruction faulted; qualified by result_valid.

Behaviour:
- Instruction fields:
  - opcode = inst[31:29], rd = inst[28:24], rs1 = inst[23:19], rs2 = inst[18:14], imm = inst[15:0].
  - imm overlaps rs2; each opcode uses only one of them.
- Opcodes:
  - 000 NOP: result = 0.
  - 001 LW: rd <= RAM[imm]; result = loaded value.
  - 010 SW: RAM[imm] <= rs1 value; result = stored value.
  - 011 ADD: rd <= rs1 + rs2; result = sum.
  - 100 SUB: rd <= rs1 - rs2.
  - 101 AND: rd <= rs1 & rs2.
  - 110 OR: rd <= rs1 | rs2.
  - 111 LI: rd <= zero-extended imm, or truncated to DATA_W if DATA_W < 16.
- Arithmetic: modulo 2^DATA_W wrap; no carry or overflow flag.
- Register 0 always reads 0; writes to r0 are discarded without error.
- Errors:
  - Any rd/rs1/rs2 index actually used by the opcode that is >= NUM_REGS → err.
  - LW/SW with imm >= MEM_DEPTH → err.
  - On err: no register or RAM write, result = 0.
- Reset (async, any time, including mid-instruction):
  - state = IDLE, inst_ready = 1, result_valid = 0, result = 0, err = 0.
  - All registers cleared to 0. RAM contents not cleared.
  - An in-flight instruction is abandoned, with no partial write.
- FSM states:
  - IDLE: inst_ready = 1. On inst_valid & inst_ready, register inst and go to EXEC.
  - EXEC: range checks done. ALU ops, LI, NOP and SW complete here: register/RAM write happens at the end of this cycle, result_valid is asserted next cycle, state goes to DONE. LW issues the synchronous RAM read and goes to MEM.
  - MEM: RAM data available; write rd, go to DONE.
  - DONE: result_valid = 1 for exactly this cycle with result/err; go to IDLE.
- inst_ready is 1 only in IDLE; inst is ignored in all other states.
- result and err hold their value until the next DONE.
- Latency, from the acceptance edge to the result_valid cycle:
  - 2 cycles for NOP/ALU/LI/SW.
  - 3 cycles for LW.
  - Back-to-back throughput: one instruction per 3 cycles (4 for LW).
- Read-after-write: the next instruction always sees the prior write, because execution is strictly sequential with no bypass needed.
- RAM is a single port: one read or one write per cycle, never both.

Test Plan:
- Reset, then LI r1,0x1234; LI r2,0x0010; ADD r3,r1,r2 → results 0x1234, 0x0010, 0x1244; err = 0; each result_valid arrives 2 cycles after acceptance.
- LI r4,0xBEEF; SW r4 @0x0005; LI r4,0; LW r5 @0x0005 → LW result 0xBEEF; result_valid arrives 3 cycles after acceptance.
- With MEM_DEPTH = 256: LW r6 @0x0100 → err = 1, result = 0, r6 unchanged. SW @0x00FF → err = 0.
- LI r1,0xFFFF (zero-extended to 0x0000FFFF); LI r2,0x0001; shift/ADD via repeated ADD to 0xFFFFFFFF (e.g. LI into 16-bit halves, then OR); ADD with 1 → result 0x00000000 (wrap); SUB 0 - 1 → 0xFFFFFFFF.
- LI r0,0x55 then ADD r7,r0,r0 → result 0, err = 0. With NUM_REGS = 8: ADD r9,r1,r1 → err = 1.
- Hold inst_valid high with a new instruction during EXEC/MEM/DONE → inst_ready = 0 and the instruction is not taken. Assert rst during MEM of an LW → result_valid stays 0, rd reads 0, inst_ready = 1 after reset release.
